// File: rtl/chess_led_pkg.sv
// Shared types and constants for the chess LED sequencer.
package chess_led_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WRITE   = 2'd1,
      HOLD    = 2'd2,
      DISPLAY = 2'd3
   } seq_state_t;

   localparam int         LED_W_DEF     = 10;
   localparam logic [1:0] PIO_DATA_ADDR = 2'd0;

endpackage

// File: rtl/led_prio_arbiter.sv
// Fixed-priority one-hot grant: lowest index that is both valid and eligible wins.
module led_prio_arbiter
   import chess_led_pkg::*;
#(
   parameter int NREQ = 3
) (
   input  logic [NREQ-1:0] i_valid,
   input  logic [NREQ-1:0] i_mask,
   output logic [NREQ-1:0] o_grant
);

   logic [NREQ-1:0] w_req;

   // x & -x isolates the lowest set bit.
   assign w_req   = i_valid & i_mask;
   assign o_grant = w_req & (~w_req + NREQ'(1));

endmodule

// File: rtl/chess_led_sequencer.sv
// Arbitrates LED patterns from several requesters onto the PIO Avalon-MM slave.
// Define LED_SEQ_BLINK_EN to build the blink logic; otherwise every pattern is solid.
module chess_led_sequencer
   import chess_led_pkg::*;
#(
   parameter int NREQ         = 3,
   parameter int LED_W        = LED_W_DEF,
   parameter int HOLD_CYCLES  = 50_000_000,
   parameter int BLINK_CYCLES = 12_500_000,
   localparam int ID_W        = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*LED_W-1:0] req_pattern,
   input  logic [NREQ-1:0]       req_blink,
   output logic [NREQ-1:0]       req_ready,
   output logic [1:0]            avm_address,
   output logic                  avm_chipselect,
   output logic                  avm_write_n,
   output logic [31:0]           avm_writedata,
   input  logic                  avm_waitrequest,
   output logic [ID_W-1:0]       active_id,
   output logic                  busy
);

   localparam int               HC_W     = $clog2(HOLD_CYCLES + 1);
   localparam logic [HC_W-1:0]  HOLD_MAX = HC_W'(HOLD_CYCLES);

   seq_state_t         r_state;
   logic [LED_W-1:0]   r_cur_pattern;
   logic [ID_W-1:0]    r_active_id;
   logic [HC_W-1:0]    r_hold_cnt;
   logic               r_cs;
   logic               r_write_n;
   logic [31:0]        r_writedata;
   logic               r_busy;

   logic [NREQ-1:0]    w_elig;
   logic [NREQ-1:0]    w_grant;
   logic               w_accept;
   logic [ID_W-1:0]    w_grant_id;
   logic [LED_W-1:0]   w_sel_pattern;
   logic               w_sel_blink;
   logic [HC_W-1:0]    w_hold_next;
   logic               w_blink_tog;
   logic [31:0]        w_toggle_data;

`ifdef LED_SEQ_BLINK_EN
   localparam int               BC_W       = $clog2(BLINK_CYCLES);
   localparam logic [BC_W-1:0]  BLINK_LAST = BC_W'(BLINK_CYCLES - 1);

   logic               r_cur_blink;
   logic [BC_W-1:0]    r_blink_cnt;
   logic               r_phase;

   assign w_blink_tog   = r_cur_blink && (r_state == HOLD || r_state == DISPLAY) &&
                          (r_blink_cnt == BLINK_LAST);
   // The toggle write shows the phase being entered, i.e. the inverse of the current one.
   assign w_toggle_data = r_phase ? 32'd0 : 32'(r_cur_pattern);
`else
   logic               w_unused_blink;

   assign w_unused_blink = ^req_blink;
   assign w_blink_tog    = 1'b0;
   assign w_toggle_data  = 32'(r_cur_pattern);
`endif

   always_comb begin
      w_elig = '0;
      case (r_state)
         IDLE, DISPLAY: w_elig = '1;
         HOLD: begin
            for (int i = 0; i < NREQ; i++) begin
               w_elig[i] = (ID_W'(i) < r_active_id);
            end
         end
         WRITE:   w_elig = '0;
         default: w_elig = '0;
      endcase
   end

   led_prio_arbiter #(.NREQ(NREQ)) u_arb (
      .i_valid (req_valid),
      .i_mask  (w_elig),
      .o_grant (w_grant)
   );

   assign w_accept  = |w_grant;
   assign req_ready = w_grant;

   // Grant is one-hot, so OR-ing the masked fields selects the winner.
   always_comb begin
      w_grant_id    = '0;
      w_sel_pattern = '0;
      w_sel_blink   = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_grant[i]) begin
            w_grant_id = ID_W'(i);
         end else begin
            w_grant_id = w_grant_id;
         end
         w_sel_pattern = w_sel_pattern | ({LED_W{w_grant[i]}} & req_pattern[i*LED_W +: LED_W]);
         w_sel_blink   = w_sel_blink | (w_grant[i] & req_blink[i]);
      end
   end

   assign w_hold_next = (r_hold_cnt < HOLD_MAX) ? (r_hold_cnt + HC_W'(1)) : r_hold_cnt;

   // Main sequencer FSM with registered bus outputs; an accept overrides everything else.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= IDLE;
         r_cur_pattern <= '0;
         r_active_id   <= '0;
         r_hold_cnt    <= '0;
         r_cs          <= 1'b0;
         r_write_n     <= 1'b1;
         r_writedata   <= 32'd0;
         r_busy        <= 1'b0;
      end else if (w_accept) begin
         r_state       <= WRITE;
         r_cur_pattern <= w_sel_pattern;
         r_active_id   <= w_grant_id;
         r_hold_cnt    <= '0;
         r_cs          <= 1'b1;
         r_write_n     <= 1'b0;
         r_writedata   <= 32'(w_sel_pattern);
         r_busy        <= 1'b1;
      end else begin
         case (r_state)
            WRITE: begin
               r_hold_cnt <= w_hold_next;
               if (!avm_waitrequest) begin
                  r_cs      <= 1'b0;
                  r_write_n <= 1'b1;
                  if (r_hold_cnt < HOLD_MAX) begin
                     r_state <= HOLD;
                     r_busy  <= 1'b1;
                  end else begin
                     r_state <= DISPLAY;
                     r_busy  <= 1'b0;
                  end
               end
            end
            HOLD: begin
               r_hold_cnt <= w_hold_next;
               if (w_blink_tog) begin
                  r_state     <= WRITE;
                  r_cs        <= 1'b1;
                  r_write_n   <= 1'b0;
                  r_writedata <= w_toggle_data;
               end else if (r_hold_cnt == HOLD_MAX) begin
                  r_state <= DISPLAY;
                  r_busy  <= 1'b0;
               end
            end
            DISPLAY: begin
               if (w_blink_tog) begin
                  r_state     <= WRITE;
                  r_cs        <= 1'b1;
                  r_write_n   <= 1'b0;
                  r_writedata <= w_toggle_data;
                  r_busy      <= 1'b1;
               end
            end
            default: r_state <= r_state;
         endcase
      end
   end

`ifdef LED_SEQ_BLINK_EN
   // Blink phase timer; runs only while a blinking pattern is held or displayed.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cur_blink <= 1'b0;
         r_blink_cnt <= '0;
         r_phase     <= 1'b1;
      end else if (w_accept) begin
         r_cur_blink <= w_sel_blink;
         r_blink_cnt <= '0;
         r_phase     <= 1'b1;
      end else if (r_cur_blink && (r_state == HOLD || r_state == DISPLAY)) begin
         if (w_blink_tog) begin
            r_blink_cnt <= '0;
            r_phase     <= ~r_phase;
         end else begin
            r_blink_cnt <= r_blink_cnt + BC_W'(1);
         end
      end
   end
`else
   logic w_unused_sel_blink;
   assign w_unused_sel_blink = w_sel_blink;
`endif

   assign avm_address    = PIO_DATA_ADDR;
   assign avm_chipselect = r_cs;
   assign avm_write_n    = r_write_n;
   assign avm_writedata  = r_writedata;
   assign active_id      = r_active_id;
   assign busy           = r_busy;

endmodule

// File: tb/tb_chess_led_sequencer.sv
// Directed self-checking bench for chess_led_sequencer (HOLD_CYCLES=8, BLINK_CYCLES=4).
module tb_chess_led_sequencer;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [2:0]  req_valid = 3'b000;
   logic [29:0] req_pattern = 30'd0;
   logic [2:0]  req_blink = 3'b000;
   logic [2:0]  req_ready;
   logic [1:0]  avm_address;
   logic        avm_chipselect;
   logic        avm_write_n;
   logic [31:0] avm_writedata;
   logic        avm_waitrequest = 1'b0;
   logic [1:0]  active_id;
   logic        busy;

   logic [9:0]  out_port;
   int          cyc = 0;
   logic [9:0]  wlog_data[$];
   int          wlog_cyc[$];
   int          n_cmp = 0;
   int          n_bad = 0;

   chess_led_sequencer #(
      .NREQ(3), .LED_W(10), .HOLD_CYCLES(8), .BLINK_CYCLES(4)
   ) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .req_valid       (req_valid),
      .req_pattern     (req_pattern),
      .req_blink       (req_blink),
      .req_ready       (req_ready),
      .avm_address     (avm_address),
      .avm_chipselect  (avm_chipselect),
      .avm_write_n     (avm_write_n),
      .avm_writedata   (avm_writedata),
      .avm_waitrequest (avm_waitrequest),
      .active_id       (active_id),
      .busy            (busy)
   );

   always #5 clk = ~clk;

   // PIO model: output register loaded by completed writes to address 0.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) out_port <= 10'd0;
      else if (avm_chipselect && !avm_write_n && !avm_waitrequest && avm_address == 2'd0)
         out_port <= avm_writedata[9:0];
   end

   always @(posedge clk) begin
      cyc = cyc + 1;
      if (reset_n && avm_chipselect && !avm_write_n && !avm_waitrequest) begin
         wlog_data.push_back(avm_writedata[9:0]);
         wlog_cyc.push_back(cyc);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      reset_n         = 1'b0;
      req_valid       = 3'b000;
      req_blink       = 3'b000;
      req_pattern     = 30'd0;
      avm_waitrequest = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      wlog_data.delete();
      wlog_cyc.delete();
   endtask

   typedef struct {
      logic [2:0] valid;
      logic [9:0] p0, p1, p2;
      logic [2:0] exp_ready;
      logic [1:0] exp_id;
      int         exp_writes;
      logic [9:0] exp_data;
   } vec_t;

   vec_t vt[7];

   initial begin
      vt[0] = '{3'b001, 10'h3FF, 10'h155, 10'h2AA, 3'b001, 2'd0, 1, 10'h3FF};
      vt[1] = '{3'b110, 10'h3FF, 10'h155, 10'h2AA, 3'b010, 2'd1, 1, 10'h155};
      vt[2] = '{3'b100, 10'h3FF, 10'h155, 10'h2AA, 3'b100, 2'd2, 1, 10'h2AA};
      vt[3] = '{3'b111, 10'h3FF, 10'h155, 10'h2AA, 3'b001, 2'd0, 1, 10'h3FF};
      vt[4] = '{3'b000, 10'h3FF, 10'h155, 10'h2AA, 3'b000, 2'd0, 0, 10'h000};
      vt[5] = '{3'b010, 10'h3FF, 10'h000, 10'h2AA, 3'b010, 2'd1, 1, 10'h000};
      vt[6] = '{3'b101, 10'h001, 10'h155, 10'h3C3, 3'b001, 2'd0, 1, 10'h001};

      // Reset then idle
      do_reset();
      chk("rst_out_port", out_port, 10'h000);
      chk("rst_active_id", active_id, 2'd0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_write_n", avm_write_n, 1'b1);
      chk("rst_writedata", avm_writedata, 32'd0);
      chk("rst_ready", req_ready, 3'b000);
      repeat (20) @(negedge clk);
      chk("idle_no_writes", wlog_data.size(), 0);
      chk("idle_cs", avm_chipselect, 1'b0);

      // Table: one accept from IDLE per vector
      for (int v = 0; v < 7; v++) begin
         do_reset();
         req_pattern = {vt[v].p2, vt[v].p1, vt[v].p0};
         req_valid   = vt[v].valid;
         #1;
         chk($sformatf("vec%0d_ready", v), req_ready, vt[v].exp_ready);
         @(negedge clk);
         req_valid = 3'b000;
         repeat (11) @(negedge clk);
         chk($sformatf("vec%0d_nwrites", v), wlog_data.size(), vt[v].exp_writes);
         if (wlog_data.size() > 0)
            chk($sformatf("vec%0d_data", v), wlog_data[0], vt[v].exp_data);
         chk($sformatf("vec%0d_id", v), active_id, vt[v].exp_id);
         chk($sformatf("vec%0d_out_port", v), out_port, vt[v].exp_data);
         chk($sformatf("vec%0d_busy", v), busy, 1'b0);
      end

      // r1 then r2: r2 waits through the whole HOLD
      do_reset();
      req_pattern = {10'h2AA, 10'h155, 10'h000};
      req_valid   = 3'b110;
      #1 chk("seq_ready_r1", req_ready, 3'b010);
      @(negedge clk);
      req_valid = 3'b100;
      chk("seq_wr1_cs", avm_chipselect, 1'b1);
      chk("seq_wr1_wn", avm_write_n, 1'b0);
      chk("seq_wr1_data", avm_writedata, 32'h155);
      chk("seq_wr1_id", active_id, 2'd1);
      chk("seq_wr1_busy", busy, 1'b1);
      chk("seq_wr1_ready", req_ready, 3'b000);
      for (int k = 2; k <= 9; k++) begin
         @(negedge clk);
         chk($sformatf("seq_hold%0d_busy", k), busy, 1'b1);
         chk($sformatf("seq_hold%0d_ready", k), req_ready, 3'b000);
         chk($sformatf("seq_hold%0d_cs", k), avm_chipselect, 1'b0);
      end
      @(negedge clk);
      chk("seq_disp_busy", busy, 1'b0);
      chk("seq_disp_ready", req_ready, 3'b100);
      @(negedge clk);
      req_valid = 3'b000;
      chk("seq_wr2_cs", avm_chipselect, 1'b1);
      chk("seq_wr2_data", avm_writedata, 32'h2AA);
      chk("seq_wr2_id", active_id, 2'd2);
      chk("seq_nwrites", wlog_data.size(), 1);

      // r2 owns HOLD, r0 preempts at hold_cnt = 3
      do_reset();
      req_pattern = {10'h2AA, 10'h000, 10'h3FF};
      req_valid   = 3'b100;
      @(negedge clk);
      req_valid = 3'b000;
      repeat (3) @(negedge clk);
      req_valid = 3'b001;
      #1 chk("pre_ready", req_ready, 3'b001);
      @(negedge clk);
      req_valid = 3'b000;
      chk("pre_cs", avm_chipselect, 1'b1);
      chk("pre_data", avm_writedata, 32'h3FF);
      chk("pre_id", active_id, 2'd0);

      // Blinking pattern
      do_reset();
      req_pattern = {10'h000, 10'h000, 10'h0F0};
      req_blink   = 3'b001;
      req_valid   = 3'b001;
      @(negedge clk);
      req_valid = 3'b000;
      req_blink = 3'b000;
      repeat (25) @(negedge clk);
`ifdef LED_SEQ_BLINK_EN
      chk("blink_nwrites_ge4", (wlog_data.size() >= 4) ? 1 : 0, 1);
      if (wlog_data.size() >= 4) begin
         chk("blink_w0", wlog_data[0], 10'h0F0);
         chk("blink_w1", wlog_data[1], 10'h000);
         chk("blink_w2", wlog_data[2], 10'h0F0);
         chk("blink_w3", wlog_data[3], 10'h000);
         chk("blink_gap1", wlog_cyc[1] - wlog_cyc[0], 5);
         chk("blink_gap2", wlog_cyc[2] - wlog_cyc[1], 5);
         chk("blink_gap3", wlog_cyc[3] - wlog_cyc[2], 5);
      end
`else
      chk("solid_nwrites", wlog_data.size(), 1);
      if (wlog_data.size() > 0) chk("solid_data", wlog_data[0], 10'h0F0);
      chk("solid_out_port", out_port, 10'h0F0);
`endif

      // Accept with three waitrequest cycles
      do_reset();
      req_pattern     = {10'h000, 10'h155, 10'h000};
      req_valid       = 3'b010;
      avm_waitrequest = 1'b1;
      @(negedge clk);
      req_valid = 3'b000;
      for (int k = 1; k <= 4; k++) begin
         if (k > 1) @(negedge clk);
         chk($sformatf("wait%0d_cs", k), avm_chipselect, 1'b1);
         chk($sformatf("wait%0d_wn", k), avm_write_n, 1'b0);
         chk($sformatf("wait%0d_data", k), avm_writedata, 32'h155);
      end
      avm_waitrequest = 1'b0;
      @(negedge clk);
      chk("wait_done_cs", avm_chipselect, 1'b0);
      chk("wait_done_busy", busy, 1'b1);
      chk("wait_out_port", out_port, 10'h155);
      repeat (4) @(negedge clk);
      chk("wait_hold_last_busy", busy, 1'b1);
      @(negedge clk);
      chk("wait_display_busy", busy, 1'b0);
      chk("wait_nwrites", wlog_data.size(), 1);

      // Reset asserted mid-strobe
      req_pattern     = {10'h000, 10'h2AA, 10'h000};
      req_valid       = 3'b010;
      avm_waitrequest = 1'b1;
      @(negedge clk);
      req_valid = 3'b000;
      chk("rstmid_cs_before", avm_chipselect, 1'b1);
      reset_n = 1'b0;
      #1;
      chk("rstmid_cs", avm_chipselect, 1'b0);
      chk("rstmid_wn", avm_write_n, 1'b1);
      chk("rstmid_busy", busy, 1'b0);
      chk("rstmid_out_port", out_port, 10'h000);
      @(negedge clk);
      reset_n         = 1'b1;
      avm_waitrequest = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
